// File: rtl/mips_pkg.sv
// Shared types for the MIPS-lite pipeline: instruction format, control bundle, ID/EX record.
// MIPS_ID_STATS_EN adds simulation instruction counters and their count tasks.
package mips_pkg;

  localparam int DATA     = 32;
  localparam int REG_NUM  = 32;
  localparam int IMM_SIZE = 16;

  typedef enum logic [5:0] {
    OP_ADD  = 6'h00, OP_ADDI = 6'h01, OP_SUB  = 6'h02, OP_SUBI = 6'h03,
    OP_MUL  = 6'h04, OP_MULI = 6'h05, OP_OR   = 6'h06, OP_ORI  = 6'h07,
    OP_AND  = 6'h08, OP_ANDI = 6'h09, OP_XOR  = 6'h0A, OP_XORI = 6'h0B,
    OP_LDW  = 6'h0C, OP_STW  = 6'h0D, OP_BZ   = 6'h0E, OP_BEQ  = 6'h0F,
    OP_JR   = 6'h10, OP_HALT = 6'h11
  } opcode_e;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_MUL = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_XOR = 3'd5;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [10:0] funct;
  } r_fmt_t;

  typedef struct packed {
    logic [5:0]          opcode;
    logic [4:0]          rs;
    logic [4:0]          rt;
    logic [IMM_SIZE-1:0] imm;
  } i_fmt_t;

  typedef union packed {
    r_fmt_t r;
    i_fmt_t i;
  } Instr;

  typedef struct packed {
    logic       RegWriteEnable;
    logic       WriteBack;
    logic       WBMux;
    logic       MemWriteEnable;
    logic       srcReg2;
    logic       jump;
    logic [2:0] ALU_op;
  } CTRL;

  typedef struct packed {
    logic            valid;
    CTRL             ctrl;
    logic [5:0]      opcode;
    logic [DATA-1:0] rs_val;
    logic [DATA-1:0] rt_val;
    logic [DATA-1:0] imm;
    logic [4:0]      dest;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [DATA-1:0] pc;
  } idex_t;

  // Even opcodes in the ALU range are register-register forms.
  function automatic logic is_rtype(input logic [5:0] op);
    return (op <= OP_XORI) && !op[0];
  endfunction

`ifdef MIPS_ID_STATS_EN
  int unsigned InstructionCount = 0;
  int unsigned ArithmeticCount  = 0;
  int unsigned LogicalCount     = 0;
  int unsigned MemoryCount      = 0;
  int unsigned BranchCount      = 0;

  task automatic CountInstruction();
    InstructionCount++;
  endtask

  task automatic CountClass(input logic [5:0] op);
    if (op <= OP_MULI)                       ArithmeticCount++;
    else if (op <= OP_XORI)                  LogicalCount++;
    else if (op == OP_LDW || op == OP_STW)   MemoryCount++;
    else if (op >= OP_BZ && op <= OP_JR)     BranchCount++;
  endtask
`endif

endpackage

// File: rtl/mips_id_stage_if.sv
// IF/ID, EX feedback, writeback and ID/EX signals of the decode stage.
interface mips_id_stage_if;
  import mips_pkg::*;

  logic        if_valid;
  Instr        if_instr;
  logic [31:0] if_pc;
  logic        ex_flush;
  logic        ex_valid;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic        id_stall;
  logic        idex_valid;
  CTRL         idex_ctrl;
  logic [5:0]  idex_opcode;
  logic [31:0] idex_rs_val;
  logic [31:0] idex_rt_val;
  logic [31:0] idex_imm;
  logic [4:0]  idex_dest;
  logic [4:0]  idex_rs;
  logic [4:0]  idex_rt;
  logic [31:0] idex_pc;
  logic        halted;

  modport master (
    output if_valid, if_instr, if_pc, ex_flush, ex_valid, ex_mem_read, ex_rd,
           wb_we, wb_addr, wb_data,
    input  id_stall, idex_valid, idex_ctrl, idex_opcode, idex_rs_val, idex_rt_val,
           idex_imm, idex_dest, idex_rs, idex_rt, idex_pc, halted
  );

  modport slave (
    input  if_valid, if_instr, if_pc, ex_flush, ex_valid, ex_mem_read, ex_rd,
           wb_we, wb_addr, wb_data,
    output id_stall, idex_valid, idex_ctrl, idex_opcode, idex_rs_val, idex_rt_val,
           idex_imm, idex_dest, idex_rs, idex_rt, idex_pc, halted
  );
endinterface

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports with writeback bypass, R0 hardwired to 0.
module mips_regfile
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [DATA-1:0] rd1,
  output logic [DATA-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [DATA-1:0] wd
);

  logic [DATA-1:0] regs [REG_NUM];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  // A same-cycle writeback is visible to the decode read.
  function automatic logic [DATA-1:0] rd_port(input logic [4:0] a);
    if (a == 5'd0)          return '0;
    if (we && wa == a)      return wd;
    return regs[a];
  endfunction

  assign rd1 = rd_port(ra1);
  assign rd2 = rd_port(ra2);

endmodule

// File: rtl/mips_id_stage.sv
// MIPS-lite decode stage: control decode, register read, load-use hazard, ID/EX register.
// Optional MIPS_ID_STATS_EN counts every live instruction loaded into ID/EX.
module mips_id_stage
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  mips_id_stage_if.slave  bus
);

  Instr            instr;
  logic [5:0]      op;
  logic [4:0]      rs, rt, rd;
  logic [DATA-1:0] rs_val, rt_val, imm;
  CTRL             ctrl_d;
  logic [4:0]      dest_d;
  logic            uses_rt, hazard, halted;
  idex_t           idex_q;

  assign instr = bus.if_instr;
  assign op    = instr.r.opcode;
  assign rs    = instr.r.rs;
  assign rt    = instr.r.rt;
  assign rd    = instr.r.rd;
  assign imm   = {{(DATA-IMM_SIZE){instr.i.imm[IMM_SIZE-1]}}, instr.i.imm};

  mips_regfile u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (rs),
    .ra2   (rt),
    .rd1   (rs_val),
    .rd2   (rt_val),
    .we    (bus.wb_we),
    .wa    (bus.wb_addr),
    .wd    (bus.wb_data)
  );

  // ALU opcodes pair up (reg, imm) so op[3:1] is the ALU function and op[0] the imm flag.
  always_comb begin
    ctrl_d  = '0;
    dest_d  = '0;
    uses_rt = is_rtype(op);
    if (op <= OP_XORI) begin
      ctrl_d.RegWriteEnable = 1'b1;
      ctrl_d.ALU_op         = op[3:1];
      ctrl_d.srcReg2        = op[0];
      dest_d                = op[0] ? rt : rd;
    end else begin
      case (op)
        OP_LDW: begin
          ctrl_d.RegWriteEnable = 1'b1;
          ctrl_d.WriteBack      = 1'b1;
          ctrl_d.WBMux          = 1'b1;
          ctrl_d.srcReg2        = 1'b1;
          ctrl_d.ALU_op         = ALU_ADD;
          dest_d                = rt;
        end
        OP_STW: begin
          ctrl_d.MemWriteEnable = 1'b1;
          ctrl_d.srcReg2        = 1'b1;
          ctrl_d.ALU_op         = ALU_ADD;
          uses_rt               = 1'b1;
        end
        OP_BZ, OP_JR: begin
          ctrl_d.jump   = 1'b1;
          ctrl_d.ALU_op = ALU_ADD;
        end
        OP_BEQ: begin
          ctrl_d.jump   = 1'b1;
          ctrl_d.ALU_op = ALU_ADD;
          uses_rt       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign hazard = bus.if_valid & bus.ex_valid & bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                  ((bus.ex_rd == rs) | (uses_rt & (bus.ex_rd == rt)));

  // A flush refetches from IF, so it releases any stall.
  assign bus.id_stall = !bus.ex_flush & (halted | hazard);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex_q <= '0;
      halted <= 1'b0;
    end else if (bus.ex_flush || halted || hazard) begin
      idex_q <= '0;
    end else begin
      idex_q.valid  <= bus.if_valid;
      idex_q.ctrl   <= bus.if_valid ? ctrl_d : '0;
      idex_q.opcode <= op;
      idex_q.rs_val <= rs_val;
      idex_q.rt_val <= rt_val;
      idex_q.imm    <= imm;
      idex_q.dest   <= dest_d;
      idex_q.rs     <= rs;
      idex_q.rt     <= rt;
      idex_q.pc     <= bus.if_pc;
      if (bus.if_valid && op == OP_HALT) halted <= 1'b1;
`ifdef MIPS_ID_STATS_EN
      if (bus.if_valid) begin
        CountInstruction();
        CountClass(op);
      end
`endif
    end
  end

  assign bus.idex_valid  = idex_q.valid;
  assign bus.idex_ctrl   = idex_q.ctrl;
  assign bus.idex_opcode = idex_q.opcode;
  assign bus.idex_rs_val = idex_q.rs_val;
  assign bus.idex_rt_val = idex_q.rt_val;
  assign bus.idex_imm    = idex_q.imm;
  assign bus.idex_dest   = idex_q.dest;
  assign bus.idex_rs     = idex_q.rs;
  assign bus.idex_rt     = idex_q.rt;
  assign bus.idex_pc     = idex_q.pc;
  assign bus.halted      = halted;

endmodule

// File: tb/tb_mips_id_stage.sv
// Scoreboard bench for mips_id_stage: directed instructions push expected ID/EX records,
// a negedge monitor pops and compares whenever idex_valid is high.
module tb_mips_id_stage;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_id_stage_if bus();

  mips_id_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    CTRL         ctrl;
    logic [5:0]  opcode;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic CTRL mk_ctrl(input bit rw, input bit wb, input bit wbm, input bit mw,
                                  input bit s2, input bit j, input logic [2:0] alu);
    CTRL c;
    c.RegWriteEnable = rw; c.WriteBack = wb; c.WBMux = wbm; c.MemWriteEnable = mw;
    c.srcReg2 = s2; c.jump = j; c.ALU_op = alu;
    return c;
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] d,
                                        input logic [4:0] s, input logic [4:0] t);
    return {op, s, t, d, 11'd0};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] t,
                                        input logic [4:0] s, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  function automatic exp_t mk_exp(input CTRL c, input logic [5:0] op, input logic [31:0] rsv,
                                  input logic [31:0] rtv, input logic [31:0] im, input logic [4:0] d,
                                  input logic [4:0] s, input logic [4:0] t, input logic [31:0] pc);
    exp_t e;
    e.ctrl = c; e.opcode = op; e.rs_val = rsv; e.rt_val = rtv; e.imm = im;
    e.dest = d; e.rs = s; e.rt = t; e.pc = pc;
    return e;
  endfunction

  // Monitor: each live ID/EX record must match the oldest expectation.
  always @(negedge clk) begin
    exp_t act, e;
    if (rst_n && bus.idex_valid) begin
      act = mk_exp(bus.idex_ctrl, bus.idex_opcode, bus.idex_rs_val, bus.idex_rt_val,
                   bus.idex_imm, bus.idex_dest, bus.idex_rs, bus.idex_rt, bus.idex_pc);
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_idex: got %h expected no valid output", act);
      end else begin
        e = q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL idex pc=%h: got %h expected %h", e.pc, act, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.wb_we = 1'b0;
    bus.if_valid = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input exp_t e);
    bus.if_valid = 1'b1;
    bus.if_instr = ins;
    bus.if_pc    = pc;
    q.push_back(e);
    tick();
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_we = 1'b1; bus.wb_addr = a; bus.wb_data = d;
  endtask

  initial begin
    bus.if_valid = 0; bus.if_instr = '0; bus.if_pc = '0;
    bus.ex_flush = 0; bus.ex_valid = 0; bus.ex_mem_read = 0; bus.ex_rd = '0;
    bus.wb_we = 0; bus.wb_addr = '0; bus.wb_data = '0;
    rst_n = 1'b0;
    tick(); tick();
    chk("reset_valid", 32'(bus.idex_valid), 32'd0);
    chk("reset_halted", 32'(bus.halted), 32'd0);
    chk("reset_pc", bus.idex_pc, 32'd0);
    chk("reset_ctrl", 32'(bus.idex_ctrl), 32'd0);
    rst_n = 1'b1;

    wb(5'd1, 32'd5); tick();
    wb(5'd2, 32'd7); tick();
    issue(rtype(6'h00, 3, 1, 2), 32'h100,
          mk_exp(mk_ctrl(1,0,0,0,0,0,3'd0), 6'h00, 32'd5, 32'd7, 32'h1800, 3, 1, 2, 32'h100));
    wb(5'd1, 32'd9);
    issue(rtype(6'h00, 3, 1, 2), 32'h104,
          mk_exp(mk_ctrl(1,0,0,0,0,0,3'd0), 6'h00, 32'd9, 32'd7, 32'h1800, 3, 1, 2, 32'h104));
    issue(itype(6'h01, 4, 1, 16'hFFFC), 32'h108,
          mk_exp(mk_ctrl(1,0,0,0,1,0,3'd0), 6'h01, 32'd9, 32'd0, 32'hFFFFFFFC, 4, 1, 4, 32'h108));
    issue(itype(6'h0D, 5, 1, 16'h0008), 32'h10C,
          mk_exp(mk_ctrl(0,0,0,1,1,0,3'd0), 6'h0D, 32'd9, 32'd0, 32'h8, 0, 1, 5, 32'h10C));
    issue(itype(6'h03, 6, 2, 16'h0001), 32'h110,
          mk_exp(mk_ctrl(1,0,0,0,1,0,3'd1), 6'h03, 32'd7, 32'd0, 32'h1, 6, 2, 6, 32'h110));
    issue(itype(6'h05, 11, 2, 16'h0003), 32'h114,
          mk_exp(mk_ctrl(1,0,0,0,1,0,3'd2), 6'h05, 32'd7, 32'd0, 32'h3, 11, 2, 11, 32'h114));
    issue(rtype(6'h0A, 12, 1, 2), 32'h118,
          mk_exp(mk_ctrl(1,0,0,0,0,0,3'd5), 6'h0A, 32'd9, 32'd7, 32'h6000, 12, 1, 2, 32'h118));
    issue(rtype(6'h08, 13, 2, 1), 32'h11C,
          mk_exp(mk_ctrl(1,0,0,0,0,0,3'd4), 6'h08, 32'd7, 32'd9, 32'h6800, 13, 2, 1, 32'h11C));
    issue(itype(6'h0C, 10, 1, 16'h0004), 32'h120,
          mk_exp(mk_ctrl(1,1,1,0,1,0,3'd0), 6'h0C, 32'd9, 32'd0, 32'h4, 10, 1, 10, 32'h120));
    issue(itype(6'h0F, 2, 1, 16'hFFF0), 32'h124,
          mk_exp(mk_ctrl(0,0,0,0,0,1,3'd0), 6'h0F, 32'd9, 32'd7, 32'hFFFFFFF0, 0, 1, 2, 32'h124));
    issue(itype(6'h0E, 0, 2, 16'h0010), 32'h128,
          mk_exp(mk_ctrl(0,0,0,0,0,1,3'd0), 6'h0E, 32'd7, 32'd0, 32'h10, 0, 2, 0, 32'h128));
    issue(itype(6'h3F, 2, 1, 16'h1234), 32'h12C,
          mk_exp(mk_ctrl(0,0,0,0,0,0,3'd0), 6'h3F, 32'd9, 32'd7, 32'h1234, 0, 1, 2, 32'h12C));

    // Load-use on rs: one bubble, then issue once the load leaves EX.
    bus.ex_valid = 1; bus.ex_mem_read = 1; bus.ex_rd = 5'd6;
    bus.if_valid = 1; bus.if_instr = rtype(6'h00, 7, 6, 1); bus.if_pc = 32'h130;
    #1 chk("stall_rs", 32'(bus.id_stall), 32'd1);
    tick();
    chk("stall_bubble", 32'(bus.idex_valid), 32'd0);
    bus.ex_mem_read = 0;
    #1 chk("stall_release", 32'(bus.id_stall), 32'd0);
    issue(rtype(6'h00, 7, 6, 1), 32'h130,
          mk_exp(mk_ctrl(1,0,0,0,0,0,3'd0), 6'h00, 32'd0, 32'd9, 32'h3800, 7, 6, 1, 32'h130));

    bus.ex_mem_read = 1; bus.ex_rd = 5'd2;
    bus.if_valid = 1; bus.if_instr = rtype(6'h00, 7, 1, 2); bus.if_pc = 32'h134;
    #1 chk("stall_rt", 32'(bus.id_stall), 32'd1);
    tick();
    chk("stall_rt_bubble", 32'(bus.idex_valid), 32'd0);

    bus.ex_rd = 5'd6;
    bus.if_valid = 1; bus.if_instr = itype(6'h07, 7, 8, 16'h0006);
    #1 chk("no_stall_ori", 32'(bus.id_stall), 32'd0);
    issue(itype(6'h07, 7, 8, 16'h0006), 32'h138,
          mk_exp(mk_ctrl(1,0,0,0,1,0,3'd3), 6'h07, 32'd0, 32'd0, 32'h6, 7, 8, 7, 32'h138));

    // Flush beats a simultaneous hazard.
    bus.ex_flush = 1;
    bus.if_valid = 1; bus.if_instr = rtype(6'h00, 7, 6, 1); bus.if_pc = 32'h13C;
    #1 chk("flush_stall", 32'(bus.id_stall), 32'd0);
    tick();
    chk("flush_bubble", 32'(bus.idex_valid), 32'd0);
    bus.ex_flush = 0; bus.ex_valid = 0; bus.ex_mem_read = 0; bus.ex_rd = '0;

    wb(5'd0, 32'hFF); tick();
    wb(5'd0, 32'hFF);
    issue(rtype(6'h06, 9, 0, 1), 32'h140,
          mk_exp(mk_ctrl(1,0,0,0,0,0,3'd3), 6'h06, 32'd0, 32'd9, 32'h4800, 9, 0, 1, 32'h140));

    // HALT squashed by a flush must not halt.
    bus.ex_flush = 1;
    bus.if_valid = 1; bus.if_instr = {6'h11, 26'd0}; bus.if_pc = 32'h144;
    tick();
    chk("flush_halt_halted", 32'(bus.halted), 32'd0);
    chk("flush_halt_valid", 32'(bus.idex_valid), 32'd0);
    bus.ex_flush = 0;

    issue({6'h11, 26'd0}, 32'h148,
          mk_exp(mk_ctrl(0,0,0,0,0,0,3'd0), 6'h11, 32'd0, 32'd0, 32'd0, 0, 0, 0, 32'h148));
    chk("halted_set", 32'(bus.halted), 32'd1);
    for (int i = 0; i < 10; i++) begin
      bus.if_valid = 1; bus.if_instr = rtype(6'h00, 3, 1, 2); bus.if_pc = 32'h14C;
      #1 chk("halt_stall", 32'(bus.id_stall), 32'd1);
      tick();
      chk("halt_bubble", 32'(bus.idex_valid), 32'd0);
    end

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_valid", 32'(bus.idex_valid), 32'd0);
    chk("rst_stall", 32'(bus.id_stall), 32'd0);
    issue(rtype(6'h00, 3, 1, 2), 32'h200,
          mk_exp(mk_ctrl(1,0,0,0,0,0,3'd0), 6'h00, 32'd0, 32'd0, 32'h1800, 3, 1, 2, 32'h200));
    tick(); tick();
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

`ifdef MIPS_ID_STATS_EN
    chk("stats_total", InstructionCount, 32'd17);
    chk("stats_arith", ArithmeticCount, 32'd7);
    chk("stats_logical", LogicalCount, 32'd4);
    chk("stats_memory", MemoryCount, 32'd2);
    chk("stats_branch", BranchCount, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish before 20000");
    $fatal(1);
  end

endmodule
